// File: rtl/lcd_pkg.sv
// Shared LCD definitions: D/C bit position, panel command opcodes, RGB565 colours
// and the one-hot state encoding used by the SPI writer.
package lcd_pkg;

  localparam int DC_BIT = 8;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] BROWN = 16'hBC40;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_GAP   = 5'b10000
  } lcd_state_e;

  function automatic logic [8:0] lcd_word(input logic is_data, input logic [7:0] b);
    return {is_data, b};
  endfunction

endpackage

// File: rtl/lcd_sclk_div.sv
// Terminal-count strobe generator: tick_o is high on every DIV-th enabled cycle.
module lcd_sclk_div #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_spi_writer.sv
// SPI mode-0 serialiser for the LCD path: one 9-bit word (D/C + byte) per
// en_write request, shifted MSB-first, acknowledged by a one-cycle wr_done.
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output lcd_state_e dbg_state
);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  lcd_state_e state_q, state_d;
  logic [7:0] sreg_q, sreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic       dc_q, dc_d, done_q, done_d, busy_q, busy_d;
  logic       div_run, tick;

  // The divider times both the CS-to-SCLK setup and every SCLK half-period.
  assign div_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  lcd_sclk_div #(.DIV(CLK_DIV)) u_div (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .en_i  (div_run),
    .clr_i (!div_run),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    dc_d      = dc_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        if (en_write) begin
          sreg_d    = data[7:0];
          dc_d      = data[DC_BIT];
          mosi_d    = data[7];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd8) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            sreg_d = sreg_q << 1;
            mosi_d = sreg_d[7];
          end
        end
      end
      ST_DONE: begin
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        gap_cnt_d = 8'd0;
        if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= 8'd0;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 8'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      dc_q      <= dc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_done   = done_q;
  assign busy      = busy_q;
  assign lcd_cs_n  = cs_n_q;
  assign lcd_sclk  = sclk_q;
  assign lcd_mosi  = mosi_q;
  assign lcd_dc    = dc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: two instances (CLK_DIV=2/GAP=3 and CLK_DIV=1/GAP=0)
// checked every cycle against a timeline model, plus an SPI slave monitor.
module tb_lcd_spi_writer;
  import lcd_pkg::*;

  localparam int A_DIV = 2;
  localparam int A_GAP = 3;
  localparam int B_DIV = 1;
  localparam int B_GAP = 0;

  logic sys_clk, sys_rst_n;
  logic a_en, a_wr_done, a_busy, a_cs_n, a_sclk, a_mosi, a_dc;
  logic b_en, b_wr_done, b_busy, b_cs_n, b_sclk, b_mosi, b_dc;
  logic [8:0] a_data, b_data;
  lcd_state_e a_state, b_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  lcd_spi_writer #(.CLK_DIV(A_DIV), .GAP_CYCLES(A_GAP)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(a_en), .data(a_data),
    .wr_done(a_wr_done), .busy(a_busy), .lcd_cs_n(a_cs_n), .lcd_sclk(a_sclk),
    .lcd_mosi(a_mosi), .lcd_dc(a_dc), .dbg_state(a_state)
  );

  lcd_spi_writer #(.CLK_DIV(B_DIV), .GAP_CYCLES(B_GAP)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(b_en), .data(b_data),
    .wr_done(b_wr_done), .busy(b_busy), .lcd_cs_n(b_cs_n), .lcd_sclk(b_sclk),
    .lcd_mosi(b_mosi), .lcd_dc(b_dc), .dbg_state(b_state)
  );

  // ---------------- clock / watchdog ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  // c = sys_clk edges since the latch edge; returns {wr_done,busy,cs_n,sclk,mosi,dc}.
  function automatic logic [5:0] model_out(input int d, input int g, input bit act,
                                           input int c, input logic [8:0] w, input logic dc);
    logic [5:0] r;
    int b;
    r = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dc};
    if (act) begin
      if (c < 17 * d) begin
        b = (c >= 3 * d) ? (c - d) / (2 * d) : 0;
        r = {1'b0, 1'b1, 1'b0, (c >= 2 * d) && ((c / d) % 2 == 0), w[7 - b], dc};
      end else if (c == 17 * d) begin
        r = {1'b1, 1'b1, 1'b0, 1'b0, w[0], dc};
      end else if (c < 17 * d + 1 + g) begin
        r = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, dc};
      end
    end
    return r;
  endfunction

  bit a_mact = 0, b_mact = 0;
  int a_mc = 0, b_mc = 0;
  logic [8:0] a_mw = '0, b_mw = '0;
  logic a_mdc = 1'b0, b_mdc = 1'b0;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      a_mact = 0; a_mc = 0; a_mdc = 1'b0;
    end else begin
      if (a_mact) begin
        a_mc++;
        if (a_mc == 17 * A_DIV + 2 + A_GAP) a_mact = 0;
      end
      if (!a_mact && a_en) begin
        a_mact = 1; a_mc = 0; a_mw = a_data; a_mdc = a_data[8];
      end
    end
    #1;
    chk("a_cycle", 32'({a_wr_done, a_busy, a_cs_n, a_sclk, a_mosi, a_dc}),
        32'(model_out(A_DIV, A_GAP, a_mact, a_mc, a_mw, a_mdc)));
    if (!a_mact || a_mc >= 17 * A_DIV + 1 + A_GAP) chk("a_state_idle", 32'(a_state), 32'(ST_IDLE));
  end

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      b_mact = 0; b_mc = 0; b_mdc = 1'b0;
    end else begin
      if (b_mact) begin
        b_mc++;
        if (b_mc == 17 * B_DIV + 2 + B_GAP) b_mact = 0;
      end
      if (!b_mact && b_en) begin
        b_mact = 1; b_mc = 0; b_mw = b_data; b_mdc = b_data[8];
      end
    end
    #1;
    chk("b_cycle", 32'({b_wr_done, b_busy, b_cs_n, b_sclk, b_mosi, b_dc}),
        32'(model_out(B_DIV, B_GAP, b_mact, b_mc, b_mw, b_mdc)));
  end

  // ---------------- SPI slave monitors / scoreboard ----------------
  logic [8:0] a_exp_q[$];
  logic [8:0] a_rx_q[$];
  logic [7:0] a_bits = '0, b_bits = '0;
  int a_nbits = 0, b_nbits = 0;
  int a_done_cnt = 0, b_done_cnt = 0;
  int a_lat_cyc = 0, b_lat_cyc = 0, b_lat_n = 0, a_cs_rise = 0, b_last_rise = 0;
  bit a_stream = 0, a_lat_valid = 0, a_prev_valid = 0, b_lat_valid = 0;
  int b_words = 0;

  always @(posedge a_sclk) if (!a_cs_n) begin
    a_bits = {a_bits[6:0], a_mosi};
    a_nbits++;
  end

  always @(negedge a_cs_n) begin
    a_bits = '0; a_nbits = 0;
    if (a_stream && a_prev_valid) chk("a_cs_gap", 32'(cyc - a_cs_rise), 32'(A_GAP + 1));
  end

  always @(posedge a_cs_n) begin
    a_cs_rise = cyc;
    if (sys_rst_n) begin
      a_rx_q.push_back({a_dc, a_bits});
      chk("a_sclk_pulses", 32'(a_nbits), 32'd8);
      a_prev_valid = a_stream;
    end
  end

  always @(posedge a_busy) begin
    // 17*2 + 2 + 3 = 39 cycles per word
    if (a_stream && a_lat_valid) chk("a_period", 32'(cyc - a_lat_cyc), 32'd39);
    a_lat_cyc = cyc;
    a_lat_valid = a_stream;
  end

  always @(posedge a_wr_done) begin
    a_done_cnt++;
    // wr_done occupies the 35th cycle counting the latch cycle as the first
    chk("a_latency", 32'(cyc - a_lat_cyc), 32'd34);
  end

  always @(posedge b_sclk) if (!b_cs_n) begin
    if (b_nbits > 0) chk("b_sclk_period", 32'(cyc - b_last_rise), 32'd2);
    b_last_rise = cyc;
    b_bits = {b_bits[6:0], b_mosi};
    b_nbits++;
  end

  always @(negedge b_cs_n) begin
    b_bits = '0; b_nbits = 0;
  end

  always @(posedge b_cs_n) if (sys_rst_n) begin
    b_words++;
    chk("b_word", 32'({b_dc, b_bits}), 32'h155);
    chk("b_sclk_pulses", 32'(b_nbits), 32'd8);
  end

  always @(posedge b_busy) begin
    if (b_lat_valid) chk("b_period", 32'(cyc - b_lat_cyc), 32'd19);
    b_lat_cyc = cyc;
    b_lat_valid = 1;
    b_lat_n++;
  end

  always @(posedge b_wr_done) b_done_cnt++;

  // ---------------- driver tasks ----------------
  // sel: 0 = a_wr_done high, 1 = a_busy low, 2 = b_busy low
  task automatic wait_for(input string name, input int sel, input int max);
    int n;
    n = 0;
    while (1) begin
      @(posedge sys_clk); #1;
      if ((sel == 0 && a_wr_done) || (sel == 1 && !a_busy) || (sel == 2 && !b_busy)) break;
      n++;
      if (n >= max) begin
        n_checks++; n_errors++;
        $display("FAIL %s timeout actual=none required=event within %0d cycles", name, max);
        break;
      end
    end
  endtask

  task automatic a_send(input logic [8:0] w);
    @(negedge sys_clk);
    a_en = 1'b1; a_data = w;
    a_exp_q.push_back(w);
    @(posedge sys_clk); #1;
    a_en = 1'b0;
    a_data = 9'($urandom_range(0, 511));
    wait_for("a_send_done", 0, 60);
    wait_for("a_send_idle", 1, 20);
  endtask

  task automatic a_wait_sclk_rises(input int k);
    int rises, n;
    logic prev;
    rises = 0; n = 0; prev = a_sclk;
    while (rises < k && n < 100) begin
      @(posedge sys_clk); #1;
      if (a_sclk && !prev) rises++;
      prev = a_sclk;
      n++;
    end
    if (rises < k) begin
      n_checks++; n_errors++;
      $display("FAIL a_sclk_rises timeout actual=%0d required=%0d", rises, k);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] stream_w[11];
  int d0, n;

  initial begin
    stream_w = '{{1'b0, CASET}, 9'h100, 9'h100, 9'h100, 9'h1EF,
                 {1'b0, RASET}, 9'h100, 9'h100, 9'h101, 9'h13F, {1'b0, RAMWR}};
    sys_rst_n = 1'b0;
    a_en = 1'b0; a_data = '0; b_en = 1'b0; b_data = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    chk("rst_a_cs_n", 32'(a_cs_n), 32'd1);
    chk("rst_a_sclk", 32'(a_sclk), 32'd0);
    chk("rst_a_mosi", 32'(a_mosi), 32'd0);
    chk("rst_a_dc", 32'(a_dc), 32'd0);
    chk("rst_a_wr_done", 32'(a_wr_done), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_state", 32'(a_state), 32'(ST_IDLE));
    chk("rst_b_cs_n", 32'(b_cs_n), 32'd1);
    chk("rst_b_state", 32'(b_state), 32'(ST_IDLE));

    // single command word, then a data word
    a_send(9'h02A);
    chk("a_first_byte", 32'(a_rx_q.size() > 0 ? a_rx_q[0] : 9'h1FF), 32'h02A);
    a_send(9'h1BC);

    // producer streaming with en_write held, data updated 2 cycles after wr_done
    a_stream = 1; a_prev_valid = 0; a_lat_valid = 0;
    @(negedge sys_clk);
    a_en = 1'b1; a_data = stream_w[0];
    for (int i = 0; i < 11; i++) begin
      a_exp_q.push_back(stream_w[i]);
      wait_for("a_stream_done", 0, 60);
      @(posedge sys_clk); @(posedge sys_clk); #1;
      if (i < 10) a_data = stream_w[i + 1];
      else a_en = 1'b0;
    end
    wait_for("a_stream_idle", 1, 20);
    a_stream = 0;

    // en_write dropped mid-byte
    d0 = a_done_cnt;
    @(negedge sys_clk);
    a_en = 1'b1; a_data = 9'h0C3;
    a_exp_q.push_back(9'h0C3);
    a_wait_sclk_rises(3);
    a_en = 1'b0;
    wait_for("a_drop_done", 0, 60);
    wait_for("a_drop_idle", 1, 20);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("a_drop_done_once", 32'(a_done_cnt - d0), 32'd1);
    chk("a_drop_cs_n", 32'(a_cs_n), 32'd1);
    chk("a_drop_state", 32'(a_state), 32'(ST_IDLE));

    // reset during the 5th bit aborts the byte silently
    d0 = a_done_cnt;
    @(negedge sys_clk);
    a_en = 1'b1; a_data = 9'h1A5;
    @(posedge sys_clk); #1;
    a_en = 1'b0;
    a_wait_sclk_rises(5);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("abort_cs_n", 32'(a_cs_n), 32'd1);
    chk("abort_sclk", 32'(a_sclk), 32'd0);
    chk("abort_mosi", 32'(a_mosi), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_wr_done", 32'(a_wr_done), 32'd0);
    repeat (40) @(posedge sys_clk);
    #1;
    chk("abort_no_done", 32'(a_done_cnt - d0), 32'd0);
    a_send(9'h05A);

    // fast instance: en_write held with a fixed word
    @(negedge sys_clk);
    b_en = 1'b1; b_data = 9'h155;
    n = 0;
    while (b_lat_n < 4 && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    b_en = 1'b0;
    chk("b_latches", 32'(b_lat_n), 32'd4);
    wait_for("b_idle", 2, 40);
    repeat (5) @(posedge sys_clk);
    #1;
    chk("b_words", 32'(b_words), 32'd4);
    chk("b_done_cnt", 32'(b_done_cnt), 32'd4);

    // scoreboard drain
    chk("a_word_count", 32'(a_rx_q.size()), 32'(a_exp_q.size()));
    chk("a_done_total", 32'(a_done_cnt), 32'd15);
    for (int i = 0; i < a_exp_q.size() && i < a_rx_q.size(); i++)
      chk($sformatf("a_word%0d", i), 32'(a_rx_q[i]), 32'(a_exp_q[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
